// File: rtl/jtag_dr_bank.sv
// JTAG instruction/data register bank: 4-bit IR, 32-bit DR shift chain with a
// per-instruction effective length, and an 8-bit user register written via DR.
module jtag_dr_bank #(
    parameter logic [31:0] IDCODE = 32'h1A3B_C0DF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tlr,
    input  logic       capture_ir,
    input  logic       shift_ir,
    input  logic       update_ir,
    input  logic       capture_dr,
    input  logic       shift_dr,
    input  logic       update_dr,
    input  logic       tdi,
    input  logic [7:0] user_in,
    output logic       tdo,
    output logic       tdo_en,
    output logic [7:0] user_out,
    output logic [3:0] ir_value
);

    localparam logic [3:0] INS_IDCODE  = 4'h1;
    localparam logic [3:0] INS_USER_WR = 4'h2;
    localparam logic [3:0] INS_USER_RD = 4'h3;

    // Effective DR chain length; unknown codes fall back to the 1-bit bypass.
    function automatic logic [5:0] dr_length(input logic [3:0] ins);
        case (ins)
            INS_IDCODE:               dr_length = 6'd32;
            INS_USER_WR, INS_USER_RD: dr_length = 6'd8;
            default:                  dr_length = 6'd1;
        endcase
    endfunction

    // Parallel value loaded into the DR on capture.
    function automatic logic [31:0] capture_value(input logic [3:0] ins,
                                                  input logic [7:0] uin,
                                                  input logic [7:0] uout);
        case (ins)
            INS_IDCODE:  capture_value = IDCODE;
            INS_USER_RD: capture_value = {24'h000000, uin};
            INS_USER_WR: capture_value = {24'h000000, uout};
            default:     capture_value = 32'h0000_0000;
        endcase
    endfunction

    logic [3:0]  ir_r, ir_s;
    logic [3:0]  ir_sr_r, ir_sr_s;
    logic [31:0] dr_sr_r, dr_sr_s;
    logic        path_r, path_s;
    logic [7:0]  user_out_r, user_out_s;
    logic        tdo_en_r, tdo_en_s;
    logic [5:0]  dr_len_s;
    logic [31:0] dr_down_s;
    logic [31:0] dr_shifted_s;

    // DR shifted by one within the active window; bits above it are kept.
    always_comb begin
        dr_len_s     = dr_length(ir_r);
        dr_down_s    = dr_sr_r >> 1;
        dr_shifted_s = dr_sr_r;
        for (int i = 0; i < 32; i++) begin
            if ((6'(i) + 6'd1) < dr_len_s) begin
                dr_shifted_s[i] = dr_down_s[i];
            end else if ((6'(i) + 6'd1) == dr_len_s) begin
                dr_shifted_s[i] = tdi;
            end else begin
                dr_shifted_s[i] = dr_sr_r[i];
            end
        end
    end

    // Next-state selection: only the highest-priority strobe takes effect.
    always_comb begin
        ir_s       = ir_r;
        ir_sr_s    = ir_sr_r;
        dr_sr_s    = dr_sr_r;
        path_s     = path_r;
        user_out_s = user_out_r;
        tdo_en_s   = tdo_en_r;
        if (tlr) begin
            ir_s     = INS_IDCODE;
            path_s   = 1'b0;
            tdo_en_s = 1'b0;
        end else if (update_ir) begin
            ir_s     = ir_sr_r;
            tdo_en_s = 1'b0;
        end else if (update_dr) begin
            tdo_en_s = 1'b0;
            if (ir_r == INS_USER_WR) begin
                user_out_s = dr_sr_r[7:0];
            end else begin
                user_out_s = user_out_r;
            end
        end else if (capture_ir) begin
            ir_sr_s  = 4'b0001;
            path_s   = 1'b1;
            tdo_en_s = 1'b1;
        end else if (capture_dr) begin
            dr_sr_s  = capture_value(ir_r, user_in, user_out_r);
            path_s   = 1'b0;
            tdo_en_s = 1'b1;
        end else if (shift_ir) begin
            ir_sr_s = {tdi, ir_sr_r[3:1]};
        end else if (shift_dr) begin
            dr_sr_s = dr_shifted_s;
        end else begin
            ir_s = ir_r;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_r       <= INS_IDCODE;
            ir_sr_r    <= 4'b0001;
            dr_sr_r    <= 32'h0000_0000;
            path_r     <= 1'b0;
            user_out_r <= 8'h00;
            tdo_en_r   <= 1'b0;
        end else begin
            ir_r       <= ir_s;
            ir_sr_r    <= ir_sr_s;
            dr_sr_r    <= dr_sr_s;
            path_r     <= path_s;
            user_out_r <= user_out_s;
            tdo_en_r   <= tdo_en_s;
        end
    end

    assign tdo      = path_r ? ir_sr_r[0] : dr_sr_r[0];
    assign tdo_en   = tdo_en_r;
    assign user_out = user_out_r;
    assign ir_value = ir_r;

endmodule

// File: tb/tb_jtag_dr_bank.sv
// Randomized and directed bench for jtag_dr_bank against an arithmetic model.
module tb_jtag_dr_bank;

    localparam logic [31:0] ID = 32'h1A3B_C0DF;

    logic       clk = 1'b0;
    logic       rst_n, tlr, capture_ir, shift_ir, update_ir;
    logic       capture_dr, shift_dr, update_dr, tdi;
    logic [7:0] user_in, user_out;
    logic       tdo, tdo_en;
    logic [3:0] ir_value;

    int checks = 0;
    int errors = 0;

    // model state
    int                m_ir, m_irsr, m_path, m_en, m_uo;
    longint unsigned   m_dr;

    jtag_dr_bank #(.IDCODE(ID)) dut (
        .clk(clk), .rst_n(rst_n), .tlr(tlr),
        .capture_ir(capture_ir), .shift_ir(shift_ir), .update_ir(update_ir),
        .capture_dr(capture_dr), .shift_dr(shift_dr), .update_dr(update_dr),
        .tdi(tdi), .user_in(user_in), .tdo(tdo), .tdo_en(tdo_en),
        .user_out(user_out), .ir_value(ir_value)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int m_len(input int ir);
        case (ir)
            1:       return 32;
            2, 3:    return 8;
            default: return 1;
        endcase
    endfunction

    task automatic model_reset();
        m_ir = 1; m_irsr = 1; m_dr = 0; m_path = 0; m_uo = 0; m_en = 0;
    endtask

    task automatic model_step();
        longint unsigned p, low;
        if (tlr) begin
            m_ir = 1; m_path = 0; m_en = 0;
        end else if (update_ir) begin
            m_ir = m_irsr; m_en = 0;
        end else if (update_dr) begin
            if (m_ir == 2) m_uo = int'(m_dr % 256);
            m_en = 0;
        end else if (capture_ir) begin
            m_irsr = 1; m_path = 1; m_en = 1;
        end else if (capture_dr) begin
            m_path = 0; m_en = 1;
            if (m_ir == 1)      m_dr = ID;
            else if (m_ir == 3) m_dr = user_in;
            else if (m_ir == 2) m_dr = m_uo;
            else                m_dr = 0;
        end else if (shift_ir) begin
            m_irsr = m_irsr / 2 + (tdi ? 8 : 0);
        end else if (shift_dr) begin
            p    = 64'd1 << m_len(m_ir);
            low  = m_dr % p;
            m_dr = m_dr - low + low / 2 + (tdi ? p / 2 : 64'd0);
        end
    endtask

    task automatic compare_all();
        int exp_tdo;
        exp_tdo = (m_path != 0) ? (m_irsr % 2) : int'(m_dr % 2);
        check_value("tdo", 32'(tdo), 32'(exp_tdo));
        check_value("tdo_en", 32'(tdo_en), 32'(m_en));
        check_value("user_out", 32'(user_out), 32'(m_uo));
        check_value("ir_value", 32'(ir_value), 32'(m_ir));
    endtask

    task automatic clear_strobes();
        tlr = 1'b0; capture_ir = 1'b0; shift_ir = 1'b0; update_ir = 1'b0;
        capture_dr = 1'b0; shift_dr = 1'b0; update_dr = 1'b0;
    endtask

    // one clock with the currently driven inputs, then compare at the falling edge
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
        clear_strobes();
    endtask

    task automatic load_ir(input logic [3:0] code);
        capture_ir = 1'b1; tick();
        for (int i = 0; i < 4; i++) begin
            tdi = code[i]; shift_ir = 1'b1; tick();
        end
        update_ir = 1'b1; tick();
    endtask

    task automatic shift_dr_bits(input int n, input logic [31:0] din, output logic [31:0] seen);
        seen = 32'h0;
        for (int i = 0; i < n; i++) begin
            seen[i] = tdo;
            tdi = din[i]; shift_dr = 1'b1; tick();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_value({tag, "_tdo"}, 32'(tdo), 32'd0);
        check_value({tag, "_tdo_en"}, 32'(tdo_en), 32'd0);
        check_value({tag, "_user_out"}, 32'(user_out), 32'h00);
        check_value({tag, "_ir"}, 32'(ir_value), 32'h1);
    endtask

    initial begin
        logic [31:0] seen;
        logic [3:0]  codes [6];
        int          r;
        codes[0] = 4'h1; codes[1] = 4'h2; codes[2] = 4'h3;
        codes[3] = 4'hF; codes[4] = 4'h7; codes[5] = 4'h0;

        rst_n = 1'b0; tdi = 1'b0; user_in = 8'h00;
        clear_strobes();
        model_reset();
        @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // IDCODE readout
        capture_dr = 1'b1; tick();
        shift_dr_bits(32, 32'h0, seen);
        check_value("idcode_seq", seen, ID);
        check_value("idcode_en", 32'(tdo_en), 32'd1);

        // IR load of USER_WR
        capture_ir = 1'b1; tick();
        seen = 32'h0;
        for (int i = 0; i < 4; i++) begin
            logic [3:0] pat;
            pat = 4'b0010;
            seen[i] = tdo;
            tdi = pat[i]; shift_ir = 1'b1; tick();
        end
        update_ir = 1'b1; tick();
        check_value("ir_seq", seen, 32'h1);
        check_value("ir_user_wr", 32'(ir_value), 32'h2);

        // USER_WR write then USER_RD readback
        capture_dr = 1'b1; tick();
        shift_dr_bits(8, 32'hA5, seen);
        update_dr = 1'b1; tick();
        check_value("user_wr", 32'(user_out), 32'hA5);
        load_ir(4'h3);
        user_in = 8'h3C;
        capture_dr = 1'b1; tick();
        shift_dr_bits(8, 32'h0, seen);
        check_value("user_rd_seq", seen, 32'h3C);

        // unknown code behaves as bypass
        load_ir(4'h7);
        capture_dr = 1'b1; tick();
        shift_dr_bits(3, 32'h5, seen);
        check_value("bypass_seq", seen, 32'h2);

        // TLR forces IDCODE, keeps user_out
        load_ir(4'h3);
        tlr = 1'b1; tick();
        check_value("tlr_ir", 32'(ir_value), 32'h1);
        check_value("tlr_en", 32'(tdo_en), 32'd0);
        check_value("tlr_user_out", 32'(user_out), 32'hA5);

        // randomized traffic
        for (int k = 0; k < 2500; k++) begin
            if (k % 60 == 0) load_ir(codes[$urandom_range(0, 5)]);
            user_in = 8'($urandom);
            tdi     = 1'($urandom);
            r = $urandom_range(0, 99);
            if (r < 2)       tlr = 1'b1;
            else if (r < 6)  update_ir = 1'b1;
            else if (r < 10) update_dr = 1'b1;
            else if (r < 14) capture_ir = 1'b1;
            else if (r < 20) capture_dr = 1'b1;
            else if (r < 35) shift_ir = 1'b1;
            else if (r < 90) shift_dr = 1'b1;
            if ($urandom_range(0, 9) == 0) begin
                case ($urandom_range(0, 5))
                    0: update_ir = 1'b1;
                    1: update_dr = 1'b1;
                    2: capture_ir = 1'b1;
                    3: capture_dr = 1'b1;
                    4: shift_ir = 1'b1;
                    default: shift_dr = 1'b1;
                endcase
            end
            tick();
        end

        // update_ir wins over capture_dr; path stays on IR
        capture_ir = 1'b1; tick();
        for (int i = 0; i < 4; i++) begin
            logic [3:0] c3;
            c3 = 4'h3;
            tdi = c3[i]; shift_ir = 1'b1; tick();
        end
        update_ir = 1'b1; capture_dr = 1'b1; tick();
        check_value("prio_ir", 32'(ir_value), 32'h3);
        check_value("prio_path", 32'(tdo), 32'd1);
        check_value("prio_en", 32'(tdo_en), 32'd0);

        // reset mid-shift
        load_ir(4'h1);
        capture_dr = 1'b1; tick();
        shift_dr_bits(5, 32'hFFFF_FFFF, seen);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_outputs("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        capture_dr = 1'b1; tick();
        shift_dr_bits(32, 32'h0, seen);
        check_value("resume_idcode", seen, ID);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jtag_dr_bank.md
JTAG_DR_BANK -- requirements
Module: jtag_dr_bank

Interface
REQ-001 SHALL have parameter IDCODE, default 32'h1A3B_C0DF, the device identification value; bit 0 SHALL be 1.
REQ-002 SHALL have port clk  input  1  the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port tlr  input  1  TAP is in Test-Logic-Reset (level).
REQ-005 SHALL have ports capture_ir, shift_ir, update_ir  input  1 each  single-cycle TAP strobes, IR path.
REQ-006 SHALL have ports capture_dr, shift_dr, update_dr  input  1 each  single-cycle TAP strobes, DR path.
REQ-007 SHALL have port tdi  input  1  serial data in, sampled only on a shift strobe.
REQ-008 SHALL have port user_in  input  8  parallel value captured by USER_RD.
REQ-009 SHALL have port tdo  output  1  serial data out.
REQ-010 SHALL have port tdo_en  output  1  TDO drive enable.
REQ-011 SHALL have port user_out  output  8  parallel register written by USER_WR.
REQ-012 SHALL have port ir_value  output  4  currently active instruction.

Function
REQ-013 SHALL hold a 4-bit instruction register (IR), a 4-bit IR shift register, a 32-bit DR shift register and a 1-bit path-select flop (0 = DR path, 1 = IR path).
REQ-014 SHALL decode the IR as: 4'h1 IDCODE; 4'h2 USER_WR; 4'h3 USER_RD; 4'hF BYPASS; every other code SHALL behave as BYPASS.
REQ-015 SHALL set the effective DR length by instruction: IDCODE 32; USER_WR 8; USER_RD 8; BYPASS 1.
REQ-016 On capture_ir, SHALL load the IR shift register with 4'b0001 and set path-select to 1.
REQ-017 On shift_ir, SHALL shift the IR shift register right by one bit, with tdi entering bit 3.
REQ-018 On update_ir, SHALL copy the IR shift register into the IR.
REQ-019 On capture_dr, SHALL clear path-select to 0 and load the DR shift register as follows:
  - IDCODE: IDCODE
  - USER_RD: {24'b0, user_in}
  - USER_WR: {24'b0, user_out}
  - BYPASS: 32'b0
REQ-020 On shift_dr, SHALL shift right by one bit only the low effective-length bits, with tdi entering bit (length-1); bits above the effective length SHALL stay unchanged.
REQ-021 On update_dr with the IR equal to USER_WR, SHALL load user_out from DR shift register bits [7:0]; update_dr SHALL have no effect under any other instruction.
REQ-022 SHALL drive tdo combinationally as bit 0 of the IR shift register when path-select is 1, else bit 0 of the DR shift register.
REQ-023 SHALL set tdo_en to 1 in the cycle after any capture strobe and clear it in the cycle after any update strobe; tdo_en SHALL be a registered output.
REQ-024 SHALL drive ir_value directly from the IR.
REQ-025 While tlr = 1, SHALL force IR to 4'h1, path-select to 0 and tdo_en to 0 every cycle, ignoring all strobes; user_out SHALL be preserved.
REQ-026 If several strobes are high in one cycle, SHALL act only on the highest priority: tlr > update_ir > update_dr > capture_ir > capture_dr > shift_ir > shift_dr.
REQ-027 With no strobe high, SHALL hold all state.
REQ-028 Continued shifting past the effective length SHALL keep recirculating tdi through the chain, with no error flag.

Reset
REQ-029 On rst_n = 0, SHALL immediately and asynchronously set:
  - IR = 4'h1
  - IR shift register = 4'b0001
  - DR shift register = 0
  - path-select = 0
  - user_out = 8'h00
  - tdo_en = 0
  - giving tdo = 0 and ir_value = 4'h1
REQ-030 Reset asserted mid-shift SHALL discard any partial shift; after release, the block SHALL resume operation on the next strobe.

Verification
REQ-031 Reset, then capture_dr followed by 32 shift_dr with tdi = 0 -> tdo sequence, LSB first, equals 32'h1A3B_C0DF; tdo_en = 1 throughout.
REQ-032 Capture_ir, then 4 shift_ir with tdi = 0,1,0,0, then update_ir -> tdo sequence 1,0,0,0 and ir_value = 4'h2.
REQ-033 With IR = 4'h2: capture_dr, 8 shift_dr carrying 8'hA5 LSB first, then update_dr -> user_out = 8'hA5; then IR = 4'h3 with user_in = 8'h3C, capture_dr and 8 shifts -> tdo sequence is 8'h3C LSB first.
REQ-034 With IR = 4'h7 (treated as BYPASS): capture_dr, then shift_dr with tdi = 1,0,1 -> tdo sequence 0,1,0 (one-cycle delay).
REQ-035 Assert tlr for one cycle with IR = 4'h3 and user_out = 8'hA5 -> ir_value = 4'h1, tdo_en = 0 and user_out still 8'hA5.
REQ-036 Assert update_ir and capture_dr in the same cycle -> only the IR update occurs and path-select is unchanged; then drop rst_n after 5 of 32 shift_dr -> all registers immediately at their reset values.
